// File: rtl/cbfp_pair_buf.sv
// Pairs sample n with sample n+BLOCK_BEATS/2 beats later for the next butterfly stage.
// Optional sticky gap checker enabled by defining CBFP_PAIRBUF_GAP_CHK_EN.
module cbfp_pair_buf #(
   parameter int ARRAY_SIZE   = 16,
   parameter int DW           = 11,
   parameter int BLOCK_BEATS  = 4,
   parameter int FRAME_BLOCKS = 8,
   parameter int BLK_W        = 3
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           valid_in,
   input  logic [ARRAY_SIZE-1:0][DW-1:0]  din_re,
   input  logic [ARRAY_SIZE-1:0][DW-1:0]  din_im,
   output logic [ARRAY_SIZE-1:0][DW-1:0]  dout_re_p,
   output logic [ARRAY_SIZE-1:0][DW-1:0]  dout_im_p,
   output logic [ARRAY_SIZE-1:0][DW-1:0]  dout_re_n,
   output logic [ARRAY_SIZE-1:0][DW-1:0]  dout_im_n,
   output logic                           valid_out,
   output logic [BLK_W-1:0]               blk_idx,
   output logic                           frame_last,
   output logic                           err_gap
);

   localparam int HALF   = BLOCK_BEATS / 2;
   localparam int CNT_W  = $clog2(BLOCK_BEATS);
   localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;

   typedef logic [ARRAY_SIZE-1:0][DW-1:0] lanes_t;

   logic [CNT_W-1:0]  r_beatCnt;
   logic [BLK_W-1:0]  r_blkCnt;
   logic [HALF-1:0]   r_slotFull;
   lanes_t            r_bufRe [HALF];
   lanes_t            r_bufIm [HALF];

   lanes_t            r_pRe;
   lanes_t            r_pIm;
   lanes_t            r_nRe;
   lanes_t            r_nIm;
   logic              r_validOut;
   logic [BLK_W-1:0]  r_blkIdx;
   logic              r_frameLast;

   logic              w_secondHalf;
   logic [HALF_W-1:0] w_wrSlot;
   logic [HALF_W-1:0] w_rdSlot;
   logic              w_emit;
   logic              w_lastBeat;
   logic              w_lastBlk;

   assign w_secondHalf = (r_beatCnt >= CNT_W'(HALF));
   assign w_wrSlot     = HALF_W'(r_beatCnt);
   assign w_rdSlot     = HALF_W'(r_beatCnt - CNT_W'(HALF));
   assign w_emit       = valid_in && w_secondHalf && r_slotFull[w_rdSlot];
   assign w_lastBeat   = (r_beatCnt == CNT_W'(BLOCK_BEATS - 1));
   assign w_lastBlk    = (r_blkCnt == BLK_W'(FRAME_BLOCKS - 1));

`ifdef CBFP_PAIRBUF_GAP_CHK_EN
   logic w_gapAbort;
   logic r_errGap;

   assign w_gapAbort = !valid_in && (r_beatCnt != '0);
`endif

   // Beat/block counters plus per-slot occupancy; a slot is freed once its pair is emitted.
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_beatCnt  <= '0;
         r_blkCnt   <= '0;
         r_slotFull <= '0;
      end else if (valid_in) begin
         if (w_lastBeat) begin
            r_beatCnt <= '0;
            r_blkCnt  <= w_lastBlk ? '0 : r_blkCnt + 1'b1;
         end else begin
            r_beatCnt <= r_beatCnt + 1'b1;
         end
         if (!w_secondHalf) begin
            r_slotFull[w_wrSlot] <= 1'b1;
         end else if (w_emit) begin
            r_slotFull[w_rdSlot] <= 1'b0;
         end
      end
`ifdef CBFP_PAIRBUF_GAP_CHK_EN
      else if (w_gapAbort) begin
         r_beatCnt  <= '0;
         r_slotFull <= '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rstn && valid_in && !w_secondHalf) begin
         r_bufRe[w_wrSlot] <= din_re;
         r_bufIm[w_wrSlot] <= din_im;
      end
   end

   // Output pair registers; data holds between pairs, strobes are single-cycle.
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_pRe       <= '0;
         r_pIm       <= '0;
         r_nRe       <= '0;
         r_nIm       <= '0;
         r_validOut  <= 1'b0;
         r_blkIdx    <= '0;
         r_frameLast <= 1'b0;
      end else begin
         r_validOut  <= w_emit;
         r_frameLast <= w_emit && w_lastBeat && w_lastBlk;
         if (w_emit) begin
            r_pRe    <= r_bufRe[w_rdSlot];
            r_pIm    <= r_bufIm[w_rdSlot];
            r_nRe    <= din_re;
            r_nIm    <= din_im;
            r_blkIdx <= r_blkCnt;
         end
      end
   end

`ifdef CBFP_PAIRBUF_GAP_CHK_EN
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_errGap <= 1'b0;
      end else if (w_gapAbort) begin
         r_errGap <= 1'b1;
      end
   end

   assign err_gap = r_errGap;
`else
   assign err_gap = 1'b0;
`endif

   assign dout_re_p  = r_pRe;
   assign dout_im_p  = r_pIm;
   assign dout_re_n  = r_nRe;
   assign dout_im_n  = r_nIm;
   assign valid_out  = r_validOut;
   assign blk_idx    = r_blkIdx;
   assign frame_last = r_frameLast;

endmodule

// File: tb/tb_cbfp_pair_buf.sv
// Self-checking bench for cbfp_pair_buf: directed traffic, a per-cycle model compare
// and hand-computed literal expectations.
module tb_cbfp_pair_buf;

   localparam int ARRAY_SIZE   = 16;
   localparam int DW           = 11;
   localparam int BLOCK_BEATS  = 4;
   localparam int FRAME_BLOCKS = 8;
   localparam int BLK_W        = 3;
   localparam int HALF         = BLOCK_BEATS / 2;

   typedef logic [ARRAY_SIZE-1:0][DW-1:0] lanes_t;

   logic             clk = 1'b0;
   logic             rstn;
   logic             valid_in;
   lanes_t           din_re;
   lanes_t           din_im;
   lanes_t           dout_re_p;
   lanes_t           dout_im_p;
   lanes_t           dout_re_n;
   lanes_t           dout_im_n;
   logic             valid_out;
   logic [BLK_W-1:0] blk_idx;
   logic             frame_last;
   logic             err_gap;

   int checks = 0;
   int errors = 0;
   bit cmpEn  = 1'b0;
   int vCount;
   int lastCount;
   int seenBlk [FRAME_BLOCKS];

   // Behavioural model state: plain integer beat/block positions and the stored half block.
   int     mBeat;
   int     mBlk;
   lanes_t mHalfRe [HALF];
   lanes_t mHalfIm [HALF];
   lanes_t mPRe;
   lanes_t mPIm;
   lanes_t mNRe;
   lanes_t mNIm;
   logic   mValid;
   logic   mLast;
   logic   mErr;
   int     mBlkIdx;

   always #5 clk = ~clk;

   cbfp_pair_buf #(
      .ARRAY_SIZE   (ARRAY_SIZE),
      .DW           (DW),
      .BLOCK_BEATS  (BLOCK_BEATS),
      .FRAME_BLOCKS (FRAME_BLOCKS),
      .BLK_W        (BLK_W)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .valid_in   (valid_in),
      .din_re     (din_re),
      .din_im     (din_im),
      .dout_re_p  (dout_re_p),
      .dout_im_p  (dout_im_p),
      .dout_re_n  (dout_re_n),
      .dout_im_n  (dout_im_n),
      .valid_out  (valid_out),
      .blk_idx    (blk_idx),
      .frame_last (frame_last),
      .err_gap    (err_gap)
   );

   // Sample value for block bl, beat b, lane j; beat 0 of later blocks uses a disjoint 900+ range.
   function automatic logic [DW-1:0] stimVal(input int bl, input int b, input int j);
      int v;
      if (b == 0 && bl != 0) v = 1000 + j - 16 * (bl - 1);
      else                   v = 16 * b + j + 64 * bl;
      return DW'(v);
   endfunction

   function automatic lanes_t laneRe(input int bl, input int b);
      lanes_t l;
      for (int j = 0; j < ARRAY_SIZE; j++) l[j] = stimVal(bl, b, j);
      return l;
   endfunction

   function automatic lanes_t laneIm(input int bl, input int b);
      lanes_t l;
      for (int j = 0; j < ARRAY_SIZE; j++) l[j] = DW'(-int'(stimVal(bl, b, j)));
      return l;
   endfunction

   // Model: pair beat k+HALF with stored beat k, one cycle later.
   always @(posedge clk) begin
      mValid <= 1'b0;
      mLast  <= 1'b0;
      if (rstn) begin
         mBeat   <= 0;
         mBlk    <= 0;
         mPRe    <= '0;
         mPIm    <= '0;
         mNRe    <= '0;
         mNIm    <= '0;
         mBlkIdx <= 0;
         mErr    <= 1'b0;
      end else if (valid_in) begin
         if (mBeat < HALF) begin
            mHalfRe[mBeat] <= din_re;
            mHalfIm[mBeat] <= din_im;
         end else begin
            mValid  <= 1'b1;
            mPRe    <= mHalfRe[mBeat - HALF];
            mPIm    <= mHalfIm[mBeat - HALF];
            mNRe    <= din_re;
            mNIm    <= din_im;
            mBlkIdx <= mBlk;
            mLast   <= (mBeat == BLOCK_BEATS - 1) && (mBlk == FRAME_BLOCKS - 1);
         end
         mBeat <= (mBeat + 1) % BLOCK_BEATS;
         if (mBeat == BLOCK_BEATS - 1) mBlk <= (mBlk + 1) % FRAME_BLOCKS;
      end
`ifdef CBFP_PAIRBUF_GAP_CHK_EN
      else if (mBeat != 0) begin
         mErr  <= 1'b1;
         mBeat <= 0;
      end
`endif
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic checkWide(input string name, input lanes_t actual, input lanes_t expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Per-cycle compare against the model, plus output statistics for scenario checks.
   initial begin
      forever begin
         @(negedge clk);
         if (cmpEn) begin
            checkOutput("valid_out", int'(valid_out), int'(mValid));
            checkOutput("frame_last", int'(frame_last), int'(mLast));
            checkOutput("err_gap", int'(err_gap), int'(mErr));
            checkOutput("blk_idx", int'(blk_idx), mBlkIdx);
            checkWide("dout_re_p", dout_re_p, mPRe);
            checkWide("dout_im_p", dout_im_p, mPIm);
            checkWide("dout_re_n", dout_re_n, mNRe);
            checkWide("dout_im_n", dout_im_n, mNIm);
            if (valid_out === 1'b1) begin
               vCount++;
               if (frame_last === 1'b1) lastCount++;
               seenBlk[blk_idx]++;
            end
         end
      end
   end

   task automatic applyStimulus(input bit v, input int bl, input int b);
      valid_in = v;
      din_re   = laneRe(bl, b);
      din_im   = laneIm(bl, b);
      @(negedge clk);
   endtask

   task automatic applyReset(input bit v, input int bl, input int b);
      rstn = 1'b1;
      applyStimulus(v, bl, b);
      rstn = 1'b0;
      valid_in = 1'b0;
   endtask

   task automatic sendBlock(input int bl, input int idle);
      for (int b = 0; b < BLOCK_BEATS; b++) applyStimulus(1'b1, bl, b);
      for (int i = 0; i < idle; i++) applyStimulus(1'b0, bl, 0);
   endtask

   task automatic clearStats();
      vCount    = 0;
      lastCount = 0;
      for (int i = 0; i < FRAME_BLOCKS; i++) seenBlk[i] = 0;
   endtask

   initial begin
      rstn     = 1'b1;
      valid_in = 1'b0;
      din_re   = '0;
      din_im   = '0;
      clearStats();
      @(negedge clk);
      @(negedge clk);
      rstn  = 1'b0;
      cmpEn = 1'b1;

      // Reset state
      checkOutput("rst_valid_out", int'(valid_out), 0);
      checkOutput("rst_re_p0", int'(dout_re_p[0]), 0);
      checkOutput("rst_blk_idx", int'(blk_idx), 0);

      // Scenario 1: single contiguous block
      clearStats();
      applyStimulus(1'b1, 0, 0);
      checkOutput("s1_b0_valid", int'(valid_out), 0);
      applyStimulus(1'b1, 0, 1);
      applyStimulus(1'b1, 0, 2);
      checkOutput("s1_b2_valid", int'(valid_out), 1);
      checkOutput("s1_b2_re_p3", int'(dout_re_p[3]), 3);
      checkOutput("s1_b2_re_n3", int'(dout_re_n[3]), 35);
      checkOutput("s1_b2_im_n3", int'($signed(dout_im_n[3])), -35);
      checkOutput("s1_b2_blk", int'(blk_idx), 0);
      applyStimulus(1'b1, 0, 3);
      checkOutput("s1_b3_re_p3", int'(dout_re_p[3]), 19);
      checkOutput("s1_b3_re_n3", int'(dout_re_n[3]), 51);
      applyStimulus(1'b0, 0, 0);
      applyStimulus(1'b0, 0, 0);
      checkOutput("s1_valid_count", vCount, 2);

      // Scenario 2: 4 valid / 4 idle, full frame
      applyReset(1'b0, 0, 0);
      applyStimulus(1'b0, 0, 0);
      clearStats();
      for (int bl = 0; bl < FRAME_BLOCKS; bl++) sendBlock(bl, 4);
      checkOutput("s2_valid_count", vCount, 16);
      checkOutput("s2_last_count", lastCount, 1);
      for (int i = 0; i < FRAME_BLOCKS; i++) checkOutput($sformatf("s2_blk%0d_count", i), seenBlk[i], 2);

      // Scenario 3: back-to-back frame, no idle cycles
      clearStats();
      applyStimulus(1'b1, 0, 0);
      applyStimulus(1'b1, 0, 1);
      applyStimulus(1'b1, 0, 2);
      checkOutput("s3_wrap_blk", int'(blk_idx), 0);
      checkOutput("s3_b0_re_p5", int'(dout_re_p[5]), 5);
      applyStimulus(1'b1, 0, 3);
      checkOutput("s3_b0_re_p5_hi", int'(dout_re_p[5]), 21);
      applyStimulus(1'b1, 1, 0);
      applyStimulus(1'b1, 1, 1);
      applyStimulus(1'b1, 1, 2);
      checkOutput("s3_b1_re_p5", int'(dout_re_p[5]), 1005);
      checkOutput("s3_b1_re_n5", int'(dout_re_n[5]), 101);
      checkOutput("s3_b1_blk", int'(blk_idx), 1);
      applyStimulus(1'b1, 1, 3);
      for (int bl = 2; bl < FRAME_BLOCKS; bl++) sendBlock(bl, 0);
      applyStimulus(1'b0, 0, 0);
      applyStimulus(1'b0, 0, 0);
      checkOutput("s3_valid_count", vCount, 16);
      checkOutput("s3_last_count", lastCount, 1);

      // Scenario 4: reset after beat 1 (reset cycle also carries a dropped beat)
      sendBlock(0, 1);
      clearStats();
      applyStimulus(1'b1, 3, 0);
      applyStimulus(1'b1, 3, 1);
      applyReset(1'b1, 5, 0);
      applyStimulus(1'b0, 0, 0);
      checkOutput("s4_partial_count", vCount, 0);
      applyStimulus(1'b1, 0, 0);
      applyStimulus(1'b1, 0, 1);
      applyStimulus(1'b1, 0, 2);
      checkOutput("s4_valid", int'(valid_out), 1);
      checkOutput("s4_blk", int'(blk_idx), 0);
      checkOutput("s4_re_p3", int'(dout_re_p[3]), 3);
      checkOutput("s4_re_n3", int'(dout_re_n[3]), 35);
      applyStimulus(1'b1, 0, 3);
      applyStimulus(1'b0, 0, 0);

      // Scenario 5: one idle cycle after beat 1
      clearStats();
      applyStimulus(1'b1, 0, 0);
      applyStimulus(1'b1, 0, 1);
      applyStimulus(1'b0, 0, 0);
`ifdef CBFP_PAIRBUF_GAP_CHK_EN
      checkOutput("s5_err_set", int'(err_gap), 1);
      applyStimulus(1'b1, 2, 0);
      checkOutput("s5_abort_valid", int'(valid_out), 0);
      applyStimulus(1'b1, 2, 1);
      applyStimulus(1'b1, 2, 2);
      checkOutput("s5_re_p3", int'(dout_re_p[3]), 987);
      checkOutput("s5_re_n3", int'(dout_re_n[3]), 163);
      applyStimulus(1'b1, 2, 3);
      applyStimulus(1'b0, 0, 0);
      applyStimulus(1'b0, 0, 0);
      checkOutput("s5_valid_count", vCount, 2);
      checkOutput("s5_err_sticky", int'(err_gap), 1);
`else
      checkOutput("s5_err_zero", int'(err_gap), 0);
      applyStimulus(1'b1, 2, 0);
      checkOutput("s5_resume_valid", int'(valid_out), 1);
      checkOutput("s5_re_p3", int'(dout_re_p[3]), 3);
      checkOutput("s5_re_n3", int'(dout_re_n[3]), 987);
      applyStimulus(1'b1, 2, 1);
      checkOutput("s5_re_p3_hi", int'(dout_re_p[3]), 19);
      checkOutput("s5_re_n3_hi", int'(dout_re_n[3]), 147);
      applyStimulus(1'b1, 2, 2);
      applyStimulus(1'b1, 2, 3);
      applyStimulus(1'b1, 3, 2);
      applyStimulus(1'b1, 3, 3);
      applyStimulus(1'b0, 0, 0);
      applyStimulus(1'b0, 0, 0);
      checkOutput("s5_valid_count", vCount, 4);
      checkOutput("s5_err_still_zero", int'(err_gap), 0);
`endif

      cmpEn = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cbfp_pair_buf.md
Name: cbfp_pair_buf

Overview:
- Sits directly downstream of the CBFP stage and upstream of the next butterfly stage.
- Takes the CBFP's normalized 16-lane complex stream, 11-bit per component, with valid_in.
- Each 64-sample block arrives as 4 beats of 16 lanes; the block pairs sample n with sample n+32 for the next butterfly.
- Buffers the first half-block and emits p/n lane pairs, tagged with block index and frame-last.

Parameters:
- ARRAY_SIZE, 16, lanes per beat
- DW, 11, signed sample width per component
- BLOCK_BEATS, 4, beats per block (must be even; pairing distance = BLOCK_BEATS/2)
- FRAME_BLOCKS, 8, blocks per frame
- BLK_W, 3, width of block index, = clog2(FRAME_BLOCKS)

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  synchronous, active-high reset (rstn=1 resets on clk edge)
- valid_in  in  1  input beat valid
- din_re  in  DW x ARRAY_SIZE  signed real, from CBFP dout_mux_re
- din_im  in  DW x ARRAY_SIZE  signed imag, from CBFP dout_mux_im
- dout_re_p  out  DW x ARRAY_SIZE  real, sample n (first half)
- dout_im_p  out  DW x ARRAY_SIZE  imag, sample n
- dout_re_n  out  DW x ARRAY_SIZE  real, sample n+32 (second half)
- dout_im_n  out  DW x ARRAY_SIZE  imag, sample n+32
- valid_out  out  1  output pair valid
- blk_idx  out  BLK_W  block index of current output pair within frame
- frame_last  out  1  high with last output beat of last block of frame
- err_gap  out  1  sticky gap error; only when macro defined, else tied 0

Behaviour:
- Reset: all outputs 0; beat_cnt=0; blk_cnt=0; half buffer contents don't-care, marked empty.
- beat_cnt (0..BLOCK_BEATS-1) advances only on valid_in=1; wraps to 0 after BLOCK_BEATS-1.
- When beat_cnt wraps, blk_cnt advances; wraps 0 after FRAME_BLOCKS-1.
- Gaps: valid_in=0 between or inside blocks holds all counters and the buffer; no output is produced.
- First half (beat_cnt < BLOCK_BEATS/2): store din into buffer slot beat_cnt; valid_out=0 next cycle.
- Second half (beat_cnt = k + BLOCK_BEATS/2): the output registers load at the next edge.
  - p = buffer slot k; n = current din.
  - blk_idx = blk_cnt.
  - valid_out=1 for one cycle.
  - frame_last=1 only if k = BLOCK_BEATS/2-1 and blk_cnt = FRAME_BLOCKS-1.
- Latency: 1 clk from the second-half input beat to valid_out; throughput is 2 output beats per 4 input beats.
- Data outputs hold their last value when valid_out=0; no arithmetic, bit-exact pass-through.
- Back-to-back blocks with no idle cycle are supported. Slot k is overwritten by the next block's beat k only after it has been read. Read occurs at beat k+2 of the previous block, always earlier.
- Reset mid-block: the partial block is discarded; valid_out=0 from the cycle after reset. The next valid_in is treated as beat 0, block 0.
- rstn and valid_in high together: reset wins; the beat is dropped.

Optional Feature:
- Macro: CBFP_PAIRBUF_GAP_CHK_EN.
- Defined:
  - valid_in=0 while 0 < beat_cnt < BLOCK_BEATS sets err_gap=1 (sticky until reset).
  - Counters are resynced: beat_cnt=0, and the partial block is discarded without output.
  - blk_cnt is not advanced.
- Undefined: gaps are tolerated as described in Behaviour; err_gap tied 0; no checker logic.

Test Plan:
- Single block, contiguous 4 beats; stimulus din_re[j]=16b+j, din_im[j]=-(16b+j) on beat b.
  - Cycle after beat 2: dout_re_p[j]=j, dout_re_n[j]=32+j, dout_im_n[j]=-(32+j), blk_idx=0.
  - Cycle after beat 3: dout_re_p[j]=16+j, dout_re_n[j]=48+j.
  - valid_out high exactly 2 cycles.
- CBFP-like traffic: 4 valid, 4 idle, repeated 8 blocks.
  - 16 output beats; blk_idx 0..7 each appearing twice.
  - frame_last=1 only on the 16th; blk_idx returns to 0 on the next frame.
- Back-to-back 8 blocks with no idle cycles:
  - Outputs identical to the previous scenario; no slot corruption.
  - Block 1 beat 0 value 1000+j must not appear in block 0 outputs.
- Reset pulse after beat 1 of a block, then a fresh block:
  - No output for the partial block.
  - Fresh block outputs as in scenario 1 with blk_idx=0.
- Macro defined, valid_in=0 for 1 cycle after beat 1:
  - err_gap=1 and stays 1.
  - The next 4 beats form a complete block with correct pairing; no output from the aborted block.
- Macro undefined, same stimulus:
  - err_gap=0.
  - The block completes after the gap: beat 2 pairs with the stored beat 0.
